// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared state encodings and handshake constants for the radix-2 divider.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } div_state_t;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;
    localparam int   DIV_WIDTH     = 32;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift/trial-subtract iteration of the divider.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             q_bit
);
    logic [WIDTH:0] minuend;
    logic [WIDTH:0] diff;

    assign minuend = {rem, next_bit};
    assign diff    = minuend - {1'b0, divisor};
    // rem < divisor always holds, so the top difference bit is exactly the borrow
    assign q_bit   = ~diff[WIDTH];
    assign rem_nxt = q_bit ? diff[WIDTH-1:0] : minuend[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU unit, result = {remainder, quotient}.
// Optional DIV_ZERO_TRAP_EN adds div_zero_o, flagging results produced by a zero divisor.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int ITER_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
`ifdef DIV_ZERO_TRAP_EN
    ,
    output logic               div_zero_o
`endif
);
    div_state_t        state;
    logic [ITER_W-1:0] cnt;
    logic [WIDTH-1:0]  dvd;
    logic [WIDTH-1:0]  dvs;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic              neg_q;
    logic              neg_r;
    logic [WIDTH-1:0]  rem_nxt;
    logic              q_bit;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .next_bit (dvd[WIDTH-1]),
        .divisor  (dvs),
        .rem_nxt  (rem_nxt),
        .q_bit    (q_bit)
    );

    assign busy_o = state != DIV_FREE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= DIV_FREE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            quo      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: if (start_i == DIV_START && !annul_i) begin
                    // operands become magnitudes; signs are restored on END entry
                    dvd   <= (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
                    dvs   <= (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
                    neg_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r <= signed_div_i && opdata1_i[WIDTH-1];
                    rem   <= '0;
                    quo   <= '0;
                    cnt   <= '0;
                    state <= (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
                DIV_BY_ZERO: begin
                    state    <= annul_i ? DIV_FREE : DIV_END;
                    result_o <= '0;
                    ready_o  <= annul_i ? DIV_NOT_READY : DIV_READY;
                end
                DIV_ON: if (annul_i) begin
                    state <= DIV_FREE;
                end else if (cnt == ITER_W'(WIDTH)) begin
                    state    <= DIV_END;
                    result_o <= {neg_r ? -rem : rem, neg_q ? -quo : quo};
                    ready_o  <= DIV_READY;
                end else begin
                    rem <= rem_nxt;
                    quo <= {quo[WIDTH-2:0], q_bit};
                    dvd <= dvd << 1;
                    cnt <= cnt + ITER_W'(1);
                end
                DIV_END: if (start_i == DIV_STOP || annul_i) begin
                    state    <= DIV_FREE;
                    result_o <= '0;
                    ready_o  <= DIV_NOT_READY;
                end
            endcase
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            div_zero_o <= 1'b0;
        else if (state == DIV_BY_ZERO)
            div_zero_o <= !annul_i;
        else if (state != DIV_END || start_i == DIV_STOP || annul_i)
            div_zero_o <= 1'b0;
    end
`endif

endmodule
